// File: rtl/instruction_loader_pkg.sv
// Shared types for the instruction loader: FSM states, error codes and small helpers.
package instruction_loader_pkg;

  localparam int BYTE_WIDTH     = 8;
  localparam int BYTES_PER_WORD = 4;
  localparam int LEN_WIDTH      = 16;

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_LEN_HI = 3'd1,
    S_LEN_LO = 3'd2,
    S_DATA   = 3'd3,
    S_CHECK  = 3'd4,
    S_DONE   = 3'd5,
    S_ERR    = 3'd6
  } state_t;

  typedef enum logic [1:0] {
    ERR_NONE    = 2'b00,
    ERR_LEN     = 2'b01,
    ERR_TIMEOUT = 2'b10,
    ERR_CSUM    = 2'b11
  } err_code_t;

  // States in which a frame is being received
  function automatic logic is_busy(input state_t s);
    return s inside {S_LEN_HI, S_LEN_LO, S_DATA, S_CHECK};
  endfunction

endpackage

// File: rtl/instruction_loader_if.sv
// Control, byte-stream and memory-write signals of the instruction loader.
interface instruction_loader_if #(
  parameter int ADDR_WIDTH = 12,
  parameter int DATA_WIDTH = 32
);

  logic                  start;
  logic [ADDR_WIDTH-1:0] base_addr;
  logic [ADDR_WIDTH-1:0] max_words;
  logic                  rx_valid;
  logic [7:0]            rx_data;
  logic                  mem_we;
  logic [ADDR_WIDTH-1:0] mem_addr;
  logic [DATA_WIDTH-1:0] mem_data;
  logic                  busy;
  logic                  done;
  logic                  error;
  logic [1:0]            err_code;
  logic [ADDR_WIDTH-1:0] words_done;

  // Host side: OS/debug control plus the UART receiver
  modport master (
    output start, base_addr, max_words, rx_valid, rx_data,
    input  mem_we, mem_addr, mem_data, busy, done, error, err_code, words_done
  );

  // Loader side
  modport slave (
    input  start, base_addr, max_words, rx_valid, rx_data,
    output mem_we, mem_addr, mem_data, busy, done, error, err_code, words_done
  );

endinterface

// File: rtl/instruction_loader_timeout.sv
// Inter-byte watchdog: counts enabled cycles since the last clear, pulses expired at the limit.
module loader_timeout #(
  parameter int TIMEOUT_CYCLES = 50_000_000
) (
  input  logic clk,
  input  logic reset,
  input  logic clear,
  input  logic enable,
  output logic expired
);

  localparam int CW = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [CW-1:0] LAST = CW'(TIMEOUT_CYCLES - 1);

  logic [CW-1:0] count_reg;

  always_ff @(posedge clk) begin
    if (reset || clear || !enable) begin
      count_reg <= '0;
    end else if (count_reg != LAST) begin
      count_reg <= count_reg + CW'(1);
    end
  end

  // A byte arriving in the expiry cycle takes priority over the timeout
  assign expired = enable && !clear && (count_reg == LAST);

endmodule

// File: rtl/instruction_loader.sv
// Receives a length-prefixed, XOR-checksummed program image byte by byte and writes it
// word by word into a partition of instruction memory.
module instruction_loader
  import instruction_loader_pkg::*;
#(
  parameter int DATA_WIDTH     = 32,
  parameter int ADDR_WIDTH     = 12,
  parameter int TIMEOUT_CYCLES = 50_000_000
) (
  input logic                 clk,
  input logic                 reset,
  instruction_loader_if.slave bus
);

  state_t                state_reg, state_next;
  logic [ADDR_WIDTH-1:0] base_reg, base_next;
  logic [ADDR_WIDTH-1:0] max_reg, max_next;
  logic [ADDR_WIDTH-1:0] len_reg, len_next;
  logic [ADDR_WIDTH-1:0] words_done_reg, words_done_next;
  logic [ADDR_WIDTH-1:0] mem_addr_reg, mem_addr_next;
  logic [DATA_WIDTH-1:0] mem_data_reg, mem_data_next;
  logic                  mem_we_reg, mem_we_next;
  logic [7:0]            len_hi_reg, len_hi_next;
  logic [7:0]            csum_reg, csum_next;
  logic [1:0]            byte_cnt_reg, byte_cnt_next;
  logic [23:0]           word_shift_reg, word_shift_next;
  logic                  error_reg, error_next;
  err_code_t             err_code_reg, err_code_next;

  logic                  busy;
  logic                  accept_start;
  logic                  timeout_expired;
  logic [LEN_WIDTH-1:0]  len_value;
  logic [ADDR_WIDTH:0]   last_addr;
  logic                  len_ok;

  assign busy         = is_busy(state_reg);
  assign accept_start = bus.start && !busy;

  loader_timeout #(
    .TIMEOUT_CYCLES(TIMEOUT_CYCLES)
  ) u_timeout (
    .clk    (clk),
    .reset  (reset),
    .clear  (bus.rx_valid || accept_start),
    .enable (busy),
    .expired(timeout_expired)
  );

  // Once N <= max_words (< 2**ADDR_WIDTH) holds, the carry bit of base+N-1 flags overflow
  assign len_value = {len_hi_reg, bus.rx_data};
  assign last_addr = {1'b0, base_reg} + len_value[ADDR_WIDTH:0] - (ADDR_WIDTH + 1)'(1);
  assign len_ok    = (len_value != '0) &&
                     (len_value <= LEN_WIDTH'(max_reg)) &&
                     !last_addr[ADDR_WIDTH];

  always_ff @(posedge clk) begin
    if (reset) begin
      state_reg <= S_IDLE;
    end else begin
      state_reg <= state_next;
    end
  end

  always_comb begin
    state_next      = state_reg;
    base_next       = base_reg;
    max_next        = max_reg;
    len_next        = len_reg;
    words_done_next = words_done_reg;
    mem_addr_next   = mem_addr_reg;
    mem_data_next   = mem_data_reg;
    mem_we_next     = 1'b0;
    len_hi_next     = len_hi_reg;
    csum_next       = csum_reg;
    byte_cnt_next   = byte_cnt_reg;
    word_shift_next = word_shift_reg;
    error_next      = error_reg;
    err_code_next   = err_code_reg;

    case (state_reg)
      S_IDLE, S_DONE, S_ERR: begin
        state_next = S_IDLE;
        if (accept_start) begin
          state_next      = S_LEN_HI;
          base_next       = bus.base_addr;
          max_next        = bus.max_words;
          len_next        = '0;
          words_done_next = '0;
          len_hi_next     = '0;
          csum_next       = '0;
          byte_cnt_next   = '0;
          word_shift_next = '0;
          error_next      = 1'b0;
          err_code_next   = ERR_NONE;
        end
      end
      S_LEN_HI: begin
        if (bus.rx_valid) begin
          len_hi_next = bus.rx_data;
          state_next  = S_LEN_LO;
        end
      end
      S_LEN_LO: begin
        if (bus.rx_valid) begin
          if (len_ok) begin
            len_next   = len_value[ADDR_WIDTH-1:0];
            state_next = S_DATA;
          end else begin
            state_next    = S_ERR;
            error_next    = 1'b1;
            err_code_next = ERR_LEN;
          end
        end
      end
      S_DATA: begin
        if (bus.rx_valid) begin
          csum_next     = csum_reg ^ bus.rx_data;
          byte_cnt_next = byte_cnt_reg + 2'd1;
          if (byte_cnt_reg == 2'(BYTES_PER_WORD - 1)) begin
            mem_we_next     = 1'b1;
            mem_addr_next   = base_reg + words_done_reg;
            mem_data_next   = DATA_WIDTH'({word_shift_reg, bus.rx_data});
            words_done_next = words_done_reg + ADDR_WIDTH'(1);
            word_shift_next = '0;
            if (words_done_next == len_reg) begin
              state_next = S_CHECK;
            end
          end else begin
            word_shift_next = {word_shift_reg[15:0], bus.rx_data};
          end
        end
      end
      S_CHECK: begin
        if (bus.rx_valid) begin
          if (bus.rx_data == csum_reg) begin
            state_next = S_DONE;
          end else begin
            state_next    = S_ERR;
            error_next    = 1'b1;
            err_code_next = ERR_CSUM;
          end
        end
      end
      default: state_next = S_IDLE;
    endcase

    // expired is never high in a cycle carrying a byte, so this cannot override a byte
    if (busy && timeout_expired) begin
      state_next    = S_ERR;
      error_next    = 1'b1;
      err_code_next = ERR_TIMEOUT;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      base_reg       <= '0;
      max_reg        <= '0;
      len_reg        <= '0;
      words_done_reg <= '0;
      mem_addr_reg   <= '0;
      mem_data_reg   <= '0;
      mem_we_reg     <= 1'b0;
      len_hi_reg     <= '0;
      csum_reg       <= '0;
      byte_cnt_reg   <= '0;
      word_shift_reg <= '0;
      error_reg      <= 1'b0;
      err_code_reg   <= ERR_NONE;
    end else begin
      base_reg       <= base_next;
      max_reg        <= max_next;
      len_reg        <= len_next;
      words_done_reg <= words_done_next;
      mem_addr_reg   <= mem_addr_next;
      mem_data_reg   <= mem_data_next;
      mem_we_reg     <= mem_we_next;
      len_hi_reg     <= len_hi_next;
      csum_reg       <= csum_next;
      byte_cnt_reg   <= byte_cnt_next;
      word_shift_reg <= word_shift_next;
      error_reg      <= error_next;
      err_code_reg   <= err_code_next;
    end
  end

  assign bus.mem_we     = mem_we_reg;
  assign bus.mem_addr   = mem_addr_reg;
  assign bus.mem_data   = mem_data_reg;
  assign bus.busy       = busy;
  assign bus.done       = (state_reg == S_DONE);
  assign bus.error      = error_reg;
  assign bus.err_code   = err_code_reg;
  assign bus.words_done = words_done_reg;

endmodule

// File: tb/tb_instruction_loader.sv
// Directed bench for instruction_loader: framing, length/timeout/checksum errors, reset.
module tb_instruction_loader;

  logic clk;
  logic reset;

  instruction_loader_if #(.ADDR_WIDTH(12), .DATA_WIDTH(32)) bus ();

  instruction_loader #(
    .DATA_WIDTH    (32),
    .ADDR_WIDTH    (12),
    .TIMEOUT_CYCLES(16)
  ) dut (
    .clk  (clk),
    .reset(reset),
    .bus  (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_tests = 0;
  int n_fail  = 0;
  int done_cnt = 0;
  logic [11:0] wr_addr [$];
  logic [31:0] wr_data [$];
  logic [7:0]  frame   [$];

  // Write and done monitor, sampled mid-cycle
  always @(negedge clk) begin
    if (bus.mem_we) begin
      wr_addr.push_back(bus.mem_addr);
      wr_data.push_back(bus.mem_data);
    end
    if (bus.done) done_cnt++;
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic start_load(input logic [11:0] base, input logic [11:0] maxw);
    bus.start     = 1'b1;
    bus.base_addr = base;
    bus.max_words = maxw;
    @(negedge clk);
    bus.start = 1'b0;
  endtask

  // One byte, then one idle cycle
  task automatic send_byte(input logic [7:0] b);
    bus.rx_valid = 1'b1;
    bus.rx_data  = b;
    @(negedge clk);
    bus.rx_valid = 1'b0;
    @(negedge clk);
  endtask

  task automatic send_frame();
    foreach (frame[i]) send_byte(frame[i]);
  endtask

  task automatic clear_log();
    wr_addr.delete();
    wr_data.delete();
  endtask

  initial begin
    reset         = 1'b1;
    bus.start     = 1'b0;
    bus.base_addr = '0;
    bus.max_words = '0;
    bus.rx_valid  = 1'b0;
    bus.rx_data   = '0;
    repeat (3) @(negedge clk);
    check("rst_busy", bus.busy, 0);
    check("rst_done", bus.done, 0);
    check("rst_error", bus.error, 0);
    check("rst_err_code", bus.err_code, 0);
    check("rst_mem_we", bus.mem_we, 0);
    check("rst_mem_addr", bus.mem_addr, 0);
    check("rst_mem_data", bus.mem_data, 0);
    check("rst_words_done", bus.words_done, 0);
    reset = 1'b0;
    @(negedge clk);

    // Good two-word load; XOR of the eight data bytes is 0x22
    clear_log();
    start_load(12'd101, 12'd100);
    check("t1_busy", bus.busy, 1);
    frame = '{8'h00, 8'h02, 8'hDE, 8'hAD, 8'hBE, 8'hEF, 8'h01, 8'h23, 8'h45, 8'h67, 8'h22};
    send_frame();
    repeat (2) @(negedge clk);
    $display("[TB] t1 writes=%0d done=%0d error=%0d", wr_addr.size(), done_cnt, bus.error);
    check("t1_nwrites", wr_addr.size(), 2);
    if (wr_addr.size() == 2) begin
      check("t1_addr0", wr_addr[0], 101);
      check("t1_data0", wr_data[0], 32'hDEADBEEF);
      check("t1_addr1", wr_addr[1], 102);
      check("t1_data1", wr_data[1], 32'h01234567);
    end
    check("t1_done", done_cnt, 1);
    check("t1_error", bus.error, 0);
    check("t1_words_done", bus.words_done, 2);
    check("t1_busy_after", bus.busy, 0);
    check("t1_hold_addr", bus.mem_addr, 102);
    check("t1_hold_data", bus.mem_data, 32'h01234567);

    // Same image, wrong checksum
    clear_log();
    start_load(12'd101, 12'd100);
    frame = '{8'h00, 8'h02, 8'hDE, 8'hAD, 8'hBE, 8'hEF, 8'h01, 8'h23, 8'h45, 8'h67, 8'h00};
    send_frame();
    repeat (2) @(negedge clk);
    $display("[TB] t2 writes=%0d error=%0d code=%0d", wr_addr.size(), bus.error, bus.err_code);
    check("t2_nwrites", wr_addr.size(), 2);
    check("t2_error", bus.error, 1);
    check("t2_err_code", bus.err_code, 2'b11);
    check("t2_no_done", done_cnt, 1);
    check("t2_busy", bus.busy, 0);

    // Partition overflow: 4090 + 10 - 1 > 4095
    clear_log();
    start_load(12'd4090, 12'd100);
    check("t3_err_cleared", bus.error, 0);
    frame = '{8'h00, 8'h0A};
    send_frame();
    $display("[TB] t3a error=%0d code=%0d", bus.error, bus.err_code);
    check("t3_ovf_error", bus.error, 1);
    check("t3_ovf_code", bus.err_code, 2'b01);
    check("t3_ovf_busy", bus.busy, 0);
    // Zero length
    start_load(12'd4090, 12'd100);
    frame = '{8'h00, 8'h00};
    send_frame();
    $display("[TB] t3b error=%0d code=%0d", bus.error, bus.err_code);
    check("t3_zero_code", bus.err_code, 2'b01);
    // Longer than the partition
    start_load(12'd0, 12'd5);
    frame = '{8'h00, 8'h06};
    send_frame();
    $display("[TB] t3c error=%0d code=%0d", bus.error, bus.err_code);
    check("t3_max_code", bus.err_code, 2'b01);
    // One word past the top of memory
    start_load(12'd4094, 12'd100);
    frame = '{8'h00, 8'h03};
    send_frame();
    check("t3_top_code", bus.err_code, 2'b01);
    check("t3_no_writes", wr_addr.size(), 0);
    // Exactly reaching the top word is legal; checksum 0x01 ^ 0x02 = 0x03
    start_load(12'd4094, 12'd100);
    frame = '{8'h00, 8'h02, 8'h00, 8'h00, 8'h00, 8'h01, 8'h00, 8'h00, 8'h00, 8'h02, 8'h03};
    send_frame();
    repeat (2) @(negedge clk);
    $display("[TB] t3d writes=%0d error=%0d done=%0d", wr_addr.size(), bus.error, done_cnt);
    check("t3_edge_nwrites", wr_addr.size(), 2);
    if (wr_addr.size() == 2) check("t3_edge_addr1", wr_addr[1], 4095);
    check("t3_edge_error", bus.error, 0);
    check("t3_edge_done", done_cnt, 2);

    // Byte timeout: error rises 16 cycles after the byte is accepted
    clear_log();
    start_load(12'd10, 12'd100);
    frame = '{8'h00, 8'h01, 8'hAA, 8'hBB};
    send_frame();
    repeat (14) @(negedge clk);
    check("t4_not_yet", bus.error, 0);
    check("t4_still_busy", bus.busy, 1);
    @(negedge clk);
    $display("[TB] t4 error=%0d code=%0d busy=%0d", bus.error, bus.err_code, bus.busy);
    check("t4_error", bus.error, 1);
    check("t4_code", bus.err_code, 2'b10);
    check("t4_busy", bus.busy, 0);
    repeat (2) @(negedge clk);
    check("t4_no_write", wr_addr.size(), 0);

    // Back-to-back bytes with stray start pulses; checksum of 01..0C is 0x0C
    clear_log();
    start_load(12'd200, 12'd100);
    frame = '{8'h00, 8'h03, 8'h01, 8'h02, 8'h03, 8'h04, 8'h05, 8'h06, 8'h07, 8'h08,
              8'h09, 8'h0A, 8'h0B, 8'h0C, 8'h0C};
    foreach (frame[i]) begin
      bus.rx_valid  = 1'b1;
      bus.rx_data   = frame[i];
      bus.start     = (i == 5) || (i == 11);
      bus.base_addr = 12'd500;
      @(negedge clk);
    end
    bus.rx_valid = 1'b0;
    bus.start    = 1'b0;
    repeat (3) @(negedge clk);
    $display("[TB] t5 writes=%0d done=%0d words=%0d", wr_addr.size(), done_cnt, bus.words_done);
    check("t5_nwrites", wr_addr.size(), 3);
    if (wr_addr.size() == 3) begin
      check("t5_addr0", wr_addr[0], 200);
      check("t5_addr2", wr_addr[2], 202);
      check("t5_data1", wr_data[1], 32'h05060708);
      check("t5_data2", wr_data[2], 32'h090A0B0C);
    end
    check("t5_done", done_cnt, 3);
    check("t5_words_done", bus.words_done, 3);
    check("t5_error", bus.error, 0);

    // Reset mid-load after five data bytes
    clear_log();
    start_load(12'd300, 12'd100);
    frame = '{8'h00, 8'h02, 8'h11, 8'h22, 8'h33, 8'h44, 8'h55};
    send_frame();
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    $display("[TB] t6 after reset busy=%0d we=%0d addr=%0h words=%0d",
             bus.busy, bus.mem_we, bus.mem_addr, bus.words_done);
    check("t6_busy", bus.busy, 0);
    check("t6_mem_we", bus.mem_we, 0);
    check("t6_mem_addr", bus.mem_addr, 0);
    check("t6_mem_data", bus.mem_data, 0);
    check("t6_words_done", bus.words_done, 0);
    check("t6_error", bus.error, 0);
    frame = '{8'h66, 8'h77, 8'h88};
    send_frame();
    check("t6_one_write", wr_addr.size(), 1);
    // Clean reload; checksum 11^22^33^44 = 0x44
    start_load(12'd0, 12'd4);
    frame = '{8'h00, 8'h01, 8'h11, 8'h22, 8'h33, 8'h44, 8'h44};
    send_frame();
    repeat (2) @(negedge clk);
    $display("[TB] t6 reload writes=%0d done=%0d", wr_addr.size(), done_cnt);
    check("t6_nwrites", wr_addr.size(), 2);
    if (wr_addr.size() == 2) begin
      check("t6_addr", wr_addr[1], 0);
      check("t6_data", wr_data[1], 32'h11223344);
    end
    check("t6_done", done_cnt, 4);
    check("t6_reload_error", bus.error, 0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
